// File: rtl/cnt_dly_macrocell.sv
// rtl/cnt_dly_macrocell.sv - SLG46620-style CNT/DLY/ONESHOT/FSM counter macrocell with edge detector
// Optional: define CNT_FSM_UP_EN to let FSM mode count up while i_up is high.
module cnt_dly_macrocell #(
    parameter int BIT_WIDTH        = 14,
    parameter bit DLY_HIGH_IS_BOTH = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [1:0]           i_mode_select,
    input  logic [1:0]           i_edge_reset_mode_select,
    input  logic                 i_resetin_timer,
    input  logic [BIT_WIDTH-1:0] i_counter_data,
    input  logic                 i_up,
    input  logic                 i_keep,
    output logic                 o_edge_detect_out,
    output logic [BIT_WIDTH-1:0] o_count,
    output logic                 o_out
);
    localparam logic [1:0] MODE_CNT     = 2'd0;
    localparam logic [1:0] MODE_DLY     = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;
    localparam logic [1:0] MODE_FSM     = 2'd3;

    localparam logic [1:0] EDGE_BOTH = 2'd0;
    localparam logic [1:0] EDGE_FALL = 2'd1;
    localparam logic [1:0] EDGE_RISE = 2'd2;
    localparam logic [1:0] EDGE_HIGH = 2'd3;

    localparam logic [BIT_WIDTH-1:0] CNT_ONE = BIT_WIDTH'(1);
    localparam logic [BIT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t               state_q, state_d;
    logic [BIT_WIDTH-1:0] count_q, count_d;
    logic [1:0]           mode_q, mode_d;
    logic                 resetin_q, resetin_d;
    logic                 target_q, target_d;
    logic                 out_q, out_d;
    logic                 rise, fall, ev, mode_change, count_zero, fsm_out;

    assign rise        = ~resetin_q & i_resetin_timer;
    assign fall        = resetin_q & ~i_resetin_timer;
    assign mode_change = (i_mode_select != mode_q);
    assign count_zero  = (count_q == '0);

    // A level-sensitive trigger makes no sense for a delay line, so DLY reinterprets it.
    always_comb begin
        ev = 1'b0;
        case (i_edge_reset_mode_select)
            EDGE_BOTH: ev = rise | fall;
            EDGE_FALL: ev = fall;
            EDGE_RISE: ev = rise;
            EDGE_HIGH: begin
                if (i_mode_select == MODE_DLY) ev = DLY_HIGH_IS_BOTH ? (rise | fall) : 1'b0;
                else                           ev = i_resetin_timer;
            end
            default:   ev = 1'b0;
        endcase
    end

`ifdef CNT_FSM_UP_EN
    assign fsm_out = i_up ? (count_q == CNT_MAX) : count_zero;
`else
    logic unused_up;
    assign unused_up = i_up;
    assign fsm_out   = count_zero;
`endif

    always_comb begin
        resetin_d = i_resetin_timer;
        mode_d    = i_mode_select;
        count_d   = count_q;
        state_d   = state_q;
        target_d  = target_q;
        out_d     = out_q;
        if (mode_change) begin
            count_d = i_counter_data;
            state_d = ST_IDLE;
            out_d   = 1'b0;
        end else begin
            case (i_mode_select)
                MODE_CNT: begin
                    if (ev) begin
                        count_d = i_counter_data;
                        out_d   = 1'b0;
                    end else if (count_zero) begin
                        count_d = i_counter_data;
                        out_d   = 1'b1;
                    end else begin
                        count_d = count_q - CNT_ONE;
                        out_d   = 1'b0;
                    end
                end
                MODE_DLY: begin
                    if (ev) begin
                        count_d  = i_counter_data;
                        target_d = i_resetin_timer;
                        state_d  = ST_RUN;
                    end else if (state_q == ST_RUN) begin
                        if (count_zero) begin
                            out_d   = target_q;
                            state_d = ST_IDLE;
                        end else begin
                            count_d = count_q - CNT_ONE;
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if (state_q == ST_IDLE) begin
                        if (ev) begin
                            count_d = i_counter_data;
                            out_d   = 1'b1;
                            state_d = ST_RUN;
                        end
                    end else if (count_zero) begin
                        out_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
                default: begin
                    if (ev) begin
                        count_d = i_counter_data;
                    end else if (!i_keep) begin
`ifdef CNT_FSM_UP_EN
                        count_d = i_up ? (count_q + CNT_ONE) : (count_q - CNT_ONE);
`else
                        count_d = count_q - CNT_ONE;
`endif
                    end
                    out_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            resetin_q <= 1'b0;
            mode_q    <= MODE_CNT;
            count_q   <= '0;
            state_q   <= ST_IDLE;
            target_q  <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            resetin_q <= resetin_d;
            mode_q    <= mode_d;
            count_q   <= count_d;
            state_q   <= state_d;
            target_q  <= target_d;
            out_q     <= out_d;
        end
    end

    // FSM output is a live decode of the count; the other modes drive a registered output.
    assign o_out             = (mode_q == MODE_FSM) ? fsm_out : out_q;
    assign o_count           = count_q;
    assign o_edge_detect_out = ev;
endmodule
